jtbubl_shared_arb: RTL and testbench
====================================

JTBUBL_SHARED_ARB -- requirements
Module: jtbubl_shared_arb

Interface
REQ-001 Parameter AW, default 13, SHALL set the address width of the shared RAM.
REQ-002 Parameter DW, default 8, SHALL set the data width.
REQ-003 clk24  in  1  SHALL be the single clock; every register updates on its rising edge.
REQ-004 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-005 main_cs, main_wrn, main_addr, main_dout  in  1/1/AW/DW  SHALL carry the main CPU request: select, write-low, address and write data.
REQ-006 sub_cs, sub_wrn, sub_addr, sub_dout  in  1/1/AW/DW  SHALL carry the sub CPU request, with the same meanings.
REQ-007 main_wait_n, sub_wait_n  out  1  SHALL be the per-CPU wait gates; low means stall.
REQ-008 main_din, sub_din  out  DW  SHALL carry the read data returned to each CPU.
REQ-009 ram_addr, ram_din, ram_we  out  AW/DW/1  SHALL drive the single-port RAM.
REQ-010 ram_dout  in  DW  SHALL be the RAM read data, valid one clock after the address is presented.

Function
REQ-011 A requester SHALL be pending when its cs=1 and its served flag=0.
REQ-012 Each wait_n SHALL be combinational: wait_n = !(cs && !served).
REQ-013 The FSM SHALL have three states: IDLE, ACC and LATCH.
REQ-014 In IDLE with a pending requester, the block SHALL register that requester's address, data and write-enable onto ram_addr/ram_din/ram_we, record the grant, and go to ACC.
REQ-015 In ACC the RAM SHALL perform the access, and the FSM SHALL go to LATCH with ram_we forced to 0.
REQ-016 In LATCH the block SHALL capture ram_dout into the granted CPU's din register (reads only), set that CPU's served flag, and return to IDLE.
REQ-017 Latency: with cs asserted at edge N in IDLE, wait_n SHALL rise after edge N+3.
REQ-018 Latency: din SHALL be valid when wait_n rises.
REQ-019 Simultaneous pending requests SHALL be resolved by round-robin: the requester not granted last wins.
REQ-020 After reset the round-robin pointer SHALL favour main.
REQ-021 A served flag SHALL clear on the first edge where its cs=0, and no other event SHALL clear it.
REQ-022 Held cs therefore SHALL never cause a second access.
REQ-023 A write SHALL assert ram_we for exactly one clock per access.
REQ-024 Each din register SHALL hold its value until that CPU's next read completes; writes SHALL leave din unchanged.
REQ-025 If cs drops while its access is in ACC or LATCH, the access SHALL complete, but the served flag SHALL remain 0.
REQ-026 A grant SHALL only change in IDLE.
REQ-027 The loser of an arbitration SHALL be granted on the next IDLE, so its worst-case wait is 6 clocks.
REQ-028 ram_addr SHALL wrap naturally at AW bits; no bounds checking is performed.

Reset
REQ-029 While rst=1: state=IDLE, ram_we=0, ram_addr=0, ram_din=0, both served=0, both din=0, and the RR pointer favours main.
REQ-030 Reset mid-access SHALL abandon the access, and ram_we SHALL be 0 on the edge following rst assertion.
REQ-031 While rst=1, wait_n SHALL still follow REQ-012, using the cleared served flags.

Structure
REQ-032 The FSM state encoding (IDLE/ACC/LATCH) and the requester index constants (MAIN=0, SUB=1) SHALL live in a shared package, jtbubl_pkg.
REQ-033 A single sub-module, jtbubl_rr2, SHALL implement the 2-way round-robin pick: inputs req[1:0] and last; outputs gnt index and valid.
REQ-034 The RAM itself SHALL remain outside this block.

Verification
REQ-035 Main read only: preload addr 0x0100=0xA5, main_cs=1/wrn=1 -> main_wait_n low 3 clocks, then main_din=0xA5, and exactly one RAM access.
REQ-036 Sub write then read: sub writes 0x5A to 0x1FFF -> ram_we high exactly 1 clock; then a sub read of 0x1FFF -> sub_din=0x5A.
REQ-037 Simultaneous requests after reset: main and sub read in the same clock -> main served first (wait 3 clocks), sub second (wait 6 clocks); repeat -> sub served first.
REQ-038 Held cs: main_cs held 20 clocks -> exactly one RAM access and main_wait_n high from the 4th clock; deassert then reassert -> a second access occurs.
REQ-039 Reset in ACC during a main write: rst pulse for 1 clock -> state IDLE, ram_we=0 next clock, served flags 0, and the access is re-issued once rst falls with cs still high.

Source files
------------

// File: rtl/jtbubl_pkg.sv
// Shared constants for the jtbubl shared-RAM arbiter: FSM state encoding
// and requester indices.
package jtbubl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACC   = 2'd1;
  localparam logic [1:0] ST_LATCH = 2'd2;

  localparam logic MAIN = 1'b0;
  localparam logic SUB  = 1'b1;

endpackage

// File: rtl/jtbubl_rr2.sv
// Two-way round-robin pick: a lone requester always wins, and on contention
// the side that did not win the previous contention is chosen.
module jtbubl_rr2
  import jtbubl_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt,
  output logic       valid
);

  // Combinational winner selection
  always_comb begin
    gnt   = MAIN;
    valid = |req;
    if (req == 2'b11) begin
      gnt = ~last;
    end else if (req[1]) begin
      gnt = SUB;
    end else begin
      gnt = MAIN;
    end
  end

endmodule

// File: rtl/jtbubl_shared_arb.sv
// Arbiter letting the main and sub CPUs share one synchronous single-port RAM;
// each access takes IDLE -> ACC -> LATCH and the loser waits for the next IDLE.
module jtbubl_shared_arb
  import jtbubl_pkg::*;
#(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk24,
  input  logic          rst,
  input  logic          main_cs,
  input  logic          main_wrn,
  input  logic [AW-1:0] main_addr,
  input  logic [DW-1:0] main_dout,
  input  logic          sub_cs,
  input  logic          sub_wrn,
  input  logic [AW-1:0] sub_addr,
  input  logic [DW-1:0] sub_dout,
  output logic          main_wait_n,
  output logic          sub_wait_n,
  output logic [DW-1:0] main_din,
  output logic [DW-1:0] sub_din,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  logic [1:0]    state_q, state_d;
  logic [1:0]    served_q, served_d;
  logic          gnt_q, gnt_d;
  logic          last_q, last_d;
  logic          rd_q, rd_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_din_q, ram_din_d;
  logic          ram_we_q, ram_we_d;
  logic [DW-1:0] main_din_q, main_din_d;
  logic [DW-1:0] sub_din_q, sub_din_d;

  logic [1:0] cs_s;
  logic [1:0] pend_s;
  logic       pick_gnt_s;
  logic       pick_valid_s;

  assign cs_s   = {sub_cs, main_cs};
  assign pend_s = cs_s & ~served_q;

  assign main_wait_n = !(main_cs && !served_q[0]);
  assign sub_wait_n  = !(sub_cs  && !served_q[1]);

  assign main_din = main_din_q;
  assign sub_din  = sub_din_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign ram_we   = ram_we_q;

  jtbubl_rr2 u_rr (
    .req   (pend_s),
    .last  (last_q),
    .gnt   (pick_gnt_s),
    .valid (pick_valid_s)
  );

  // Next-state logic for the access FSM, RAM port and per-CPU bookkeeping
  always_comb begin
    state_d    = state_q;
    served_d   = served_q & cs_s;
    gnt_d      = gnt_q;
    last_d     = last_q;
    rd_d       = rd_q;
    ram_addr_d = ram_addr_q;
    ram_din_d  = ram_din_q;
    ram_we_d   = ram_we_q;
    main_din_d = main_din_q;
    sub_din_d  = sub_din_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid_s) begin
          gnt_d = pick_gnt_s;
          // The pointer only moves on contention, so uncontested grants keep the turn order.
          if (pend_s == 2'b11) begin
            last_d = pick_gnt_s;
          end else begin
            last_d = last_q;
          end
          if (pick_gnt_s == SUB) begin
            ram_addr_d = sub_addr;
            ram_din_d  = sub_dout;
            ram_we_d   = !sub_wrn;
            rd_d       = sub_wrn;
          end else begin
            ram_addr_d = main_addr;
            ram_din_d  = main_dout;
            ram_we_d   = !main_wrn;
            rd_d       = main_wrn;
          end
          state_d = ST_ACC;
        end else begin
          ram_we_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_ACC: begin
        ram_we_d = 1'b0;
        state_d  = ST_LATCH;
      end
      ST_LATCH: begin
        ram_we_d = 1'b0;
        if (rd_q) begin
          if (gnt_q == SUB) begin
            sub_din_d = ram_dout;
          end else begin
            main_din_d = ram_dout;
          end
        end else begin
          main_din_d = main_din_q;
        end
        // A requester that let go mid-access stays unserved.
        served_d[gnt_q] = cs_s[gnt_q];
        state_d         = ST_IDLE;
      end
      default: begin
        ram_we_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge clk24) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      served_q   <= 2'b00;
      gnt_q      <= MAIN;
      last_q     <= SUB;
      rd_q       <= 1'b0;
      ram_addr_q <= {AW{1'b0}};
      ram_din_q  <= {DW{1'b0}};
      ram_we_q   <= 1'b0;
      main_din_q <= {DW{1'b0}};
      sub_din_q  <= {DW{1'b0}};
    end else begin
      state_q    <= state_d;
      served_q   <= served_d;
      gnt_q      <= gnt_d;
      last_q     <= last_d;
      rd_q       <= rd_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      ram_we_q   <= ram_we_d;
      main_din_q <= main_din_d;
      sub_din_q  <= sub_din_d;
    end
  end

endmodule

// File: tb/tb_jtbubl_shared_arb.sv
// Directed bench for jtbubl_shared_arb with a synchronous RAM model and a
// transaction-level reference model compared every clock.
module tb_jtbubl_shared_arb;
  import jtbubl_pkg::*;

  localparam int AW = 13;
  localparam int DW = 8;

  logic          clk24 = 1'b0;
  logic          rst;
  logic          main_cs, main_wrn, sub_cs, sub_wrn;
  logic [AW-1:0] main_addr, sub_addr, ram_addr;
  logic [DW-1:0] main_dout, sub_dout, main_din, sub_din, ram_din, ram_dout;
  logic          main_wait_n, sub_wait_n, ram_we;

  int nvec  = 0;
  int nfail = 0;
  int acc_dut = 0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // reference model state
  bit            m_init = 1'b0;
  bit            m_served [2];
  logic [DW-1:0] m_din [2];
  logic [DW-1:0] m_mem [0:(1<<AW)-1];
  bit            m_busy, m_wr, m_owner, m_fav;
  int            m_rem;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;

  jtbubl_shared_arb #(.AW(AW), .DW(DW)) dut (
    .clk24(clk24), .rst(rst),
    .main_cs(main_cs), .main_wrn(main_wrn), .main_addr(main_addr), .main_dout(main_dout),
    .sub_cs(sub_cs), .sub_wrn(sub_wrn), .sub_addr(sub_addr), .sub_dout(sub_dout),
    .main_wait_n(main_wait_n), .sub_wait_n(sub_wait_n),
    .main_din(main_din), .sub_din(sub_din),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clk24 = ~clk24;

  // synchronous RAM: data appears one clock after the address
  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = 8'h00;
    mem[13'h0100] = 8'hA5;
    mem[13'h0200] = 8'hC3;
    forever begin
      @(posedge clk24);
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  always @(posedge clk24) if (dut.state_q == ST_ACC) acc_dut++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an access occupies the RAM for 3 clocks from its grant.
  initial begin
    logic [1:0] cs, pend;
    for (int i = 0; i < (1<<AW); i++) m_mem[i] = 8'h00;
    m_mem[13'h0100] = 8'hA5;
    m_mem[13'h0200] = 8'hC3;
    forever begin
      @(posedge clk24);
      cs = {sub_cs, main_cs};
      if (rst) begin
        m_init = 1'b1;
        m_served[0] = 1'b0; m_served[1] = 1'b0;
        m_din[0] = 8'h00;   m_din[1] = 8'h00;
        m_busy = 1'b0; m_fav = MAIN; m_rem = 0;
      end else begin
        pend = cs & ~{m_served[1], m_served[0]};
        for (int i = 0; i < 2; i++) if (!cs[i]) m_served[i] = 1'b0;
        if (m_busy) begin
          if (m_rem == 1) begin
            m_busy = 1'b0;
            if (!m_wr) m_din[m_owner] = m_mem[m_addr];
            if (cs[m_owner]) m_served[m_owner] = 1'b1;
          end else begin
            m_rem--;
          end
        end else if (pend != 2'b00) begin
          if (pend == 2'b11) begin
            m_owner = m_fav;
            m_fav   = ~m_fav;
          end else begin
            m_owner = pend[1];
          end
          m_wr    = m_owner ? !sub_wrn : !main_wrn;
          m_addr  = m_owner ? sub_addr : main_addr;
          m_wdata = m_owner ? sub_dout : main_dout;
          if (m_wr) m_mem[m_addr] = m_wdata;
          m_busy = 1'b1;
          m_rem  = 2;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk24) begin
    if (m_init) begin
      chk("main_wait_n", main_wait_n, !(main_cs && !m_served[0]));
      chk("sub_wait_n",  sub_wait_n,  !(sub_cs  && !m_served[1]));
      chk("main_din", main_din, m_din[0]);
      chk("sub_din",  sub_din,  m_din[1]);
      chk("ram_we", ram_we, m_busy && (m_rem == 2) && m_wr);
      if (m_busy) chk("ram_addr", ram_addr, m_addr);
      if (m_busy && m_wr) chk("ram_din", ram_din, m_wdata);
    end
  end

  task automatic step();
    @(posedge clk24);
    #1;
  endtask

  task automatic wait_both(output int mc, output int sc, output int wc);
    mc = 0; sc = 0; wc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk24);
      if (main_wait_n && sub_wait_n) break;
      if (!main_wait_n) mc++;
      if (!sub_wait_n)  sc++;
      if (ram_we)       wc++;
    end
    chk("wait_timeout", {31'd0, main_wait_n && sub_wait_n}, 32'd1);
  endtask

  initial begin
    int mc, sc, wc, a0;
    rst = 1'b1;
    main_cs = 1'b0; main_wrn = 1'b1; main_addr = '0; main_dout = '0;
    sub_cs  = 1'b0; sub_wrn  = 1'b1; sub_addr  = '0; sub_dout  = '0;
    repeat (3) step();
    chk("rst_ram_we", ram_we, 1'b0);
    chk("rst_ram_addr", ram_addr, 13'h0000);
    chk("rst_main_din", main_din, 8'h00);
    chk("rst_sub_din", sub_din, 8'h00);
    rst = 1'b0;
    step();

    // main read of a preloaded location
    a0 = acc_dut;
    main_addr = 13'h0100; main_wrn = 1'b1; main_cs = 1'b1;
    wait_both(mc, sc, wc);
    chk("t1_wait", mc, 3);
    chk("t1_din", main_din, 8'hA5);
    step(); step();
    chk("t1_accesses", acc_dut - a0, 1);
    main_cs = 1'b0;
    step();

    // sub write at the top address, then read it back
    sub_addr = 13'h1FFF; sub_dout = 8'h5A; sub_wrn = 1'b0; sub_cs = 1'b1;
    wait_both(mc, sc, wc);
    chk("t2_we_clocks", wc, 1);
    chk("t2_din_kept", sub_din, 8'h00);
    sub_cs = 1'b0;
    step();
    chk("t2_mem", mem[13'h1FFF], 8'h5A);
    sub_wrn = 1'b1; sub_cs = 1'b1;
    wait_both(mc, sc, wc);
    chk("t2_rd_din", sub_din, 8'h5A);
    sub_cs = 1'b0;
    step();

    // simultaneous reads: main wins first, sub wins the repeat
    main_addr = 13'h0100; sub_addr = 13'h0200;
    main_cs = 1'b1; sub_cs = 1'b1;
    wait_both(mc, sc, wc);
    chk("t3a_main_wait", mc, 3);
    chk("t3a_sub_wait", sc, 6);
    chk("t3a_sub_din", sub_din, 8'hC3);
    main_cs = 1'b0; sub_cs = 1'b0;
    step();
    main_cs = 1'b1; sub_cs = 1'b1;
    wait_both(mc, sc, wc);
    chk("t3b_main_wait", mc, 6);
    chk("t3b_sub_wait", sc, 3);
    main_cs = 1'b0; sub_cs = 1'b0;
    step();

    // held cs gives a single access; a fresh cs gives another
    a0 = acc_dut;
    main_cs = 1'b1;
    wait_both(mc, sc, wc);
    chk("t4_wait", mc, 3);
    repeat (17) step();
    chk("t4_wait_n_held", main_wait_n, 1'b1);
    chk("t4_accesses", acc_dut - a0, 1);
    main_cs = 1'b0;
    step();
    main_cs = 1'b1;
    wait_both(mc, sc, wc);
    step();
    chk("t4_accesses2", acc_dut - a0, 2);
    main_cs = 1'b0;
    step();

    // reset while a main write sits in ACC
    a0 = acc_dut;
    main_addr = 13'h0042; main_dout = 8'h3C; main_wrn = 1'b0; main_cs = 1'b1;
    step();
    rst = 1'b1;
    step();
    chk("t5_state", dut.state_q, ST_IDLE);
    chk("t5_we", ram_we, 1'b0);
    chk("t5_wait_n", main_wait_n, 1'b0);
    chk("t5_din", main_din, 8'h00);
    rst = 1'b0;
    wait_both(mc, sc, wc);
    chk("t5_reissue_wait", mc, 3);
    step();
    chk("t5_accesses", acc_dut - a0, 2);
    chk("t5_mem", mem[13'h0042], 8'h3C);
    main_cs = 1'b0;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
